// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared Ethernet constants and types for the receive FCS checker and the
// future transmit FCS generator.
//   CRC32_*        reflected CRC-32 polynomial, preset and good-frame residue
//   FCS_BYTES      number of trailing FCS bytes in a frame
//   ETH_MIN/MAX_*  legal frame length bounds, DA through FCS
//   rx_state_t     receive FSM state encoding
// -----------------------------------------------------------------------------
package eth_pkg;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

   localparam int FCS_BYTES     = 4;
   localparam int ETH_MIN_FRAME = 64;
   localparam int ETH_MAX_FRAME = 1518;

   // FILL holds fewer than FCS_BYTES bytes, STREAM holds exactly FCS_BYTES.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2
   } rx_state_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// -----------------------------------------------------------------------------
// eth_crc32_d8
// Combinational one-byte step of the reflected CRC-32 (LSB of data first).
//   crc       current CRC register
//   data      byte to fold in, bit 0 first on the wire
//   crc_next  CRC register after the byte
// -----------------------------------------------------------------------------
module eth_crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [7:0]  data,
   output logic [31:0] crc_next
);

   // NOTE: blocking assignments are deliberate here: each bit step must see
   // the result of the previous step within the same evaluation.
   always_comb begin
      crc_next = crc;
      for (int i = 0; i < 8; i++) begin
         if (crc_next[0] ^ data[i]) begin
            crc_next = (crc_next >> 1) ^ CRC32_POLY_REFL;
         end else begin
            crc_next = crc_next >> 1;
         end
      end
   end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// -----------------------------------------------------------------------------
// eth_rx_fcs_check
// Receive-side FCS checker. Runs CRC-32 over every byte of a frame (FCS
// included), strips the 4 FCS bytes with a 4-byte delay line and reports one
// status pulse per frame.
//   i_rx_clk, i_rst_n       clock, synchronous active-low reset
//   i_valid/i_byte          incoming byte stream, i_sof/i_eof frame markers
//   i_abort                 rx error / carrier loss, ends the current frame
//   o_valid/o_data          forwarded DA..payload bytes, o_sof/o_eof markers
//   o_stat_valid            one-cycle status pulse with o_crc_ok, o_runt,
//                           o_giant, o_aborted and o_len (length incl. FCS)
// -----------------------------------------------------------------------------
module eth_rx_fcs_check
   import eth_pkg::*;
#(
   parameter int MIN_FRAME = ETH_MIN_FRAME,
   parameter int MAX_FRAME = ETH_MAX_FRAME,
   parameter int LEN_W     = 11
)(
   input  logic             i_rx_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [7:0]       i_byte,
   input  logic             i_sof,
   input  logic             i_eof,
   input  logic             i_abort,
   output logic             o_valid,
   output logic [7:0]       o_data,
   output logic             o_sof,
   output logic             o_eof,
   output logic             o_stat_valid,
   output logic             o_crc_ok,
   output logic             o_runt,
   output logic             o_giant,
   output logic             o_aborted,
   output logic [LEN_W-1:0] o_len
);

   rx_state_t state_q, state_d;

   logic [FCS_BYTES-1:0][7:0] dl_q;     // [0] newest, [FCS_BYTES-1] oldest
   logic [1:0]                fill_q, fill_d;
   logic [31:0]               crc_q;
   logic [LEN_W-1:0]          len_q;
   logic                      fwd_q;    // a byte of this frame was already forwarded

   logic             in_frame, kill, take, restart, close_old, ending, push;
   logic [31:0]      crc_base, crc_nx;
   logic [LEN_W-1:0] len_base, len_nx;

   logic             vld_d, sof_d, eof_d, stat_d, ok_d, runt_d, giant_d, abt_d;
   logic [7:0]       data_d;
   logic [LEN_W-1:0] slen_d;

   // --------------------------------------------------------------------------
   // Event decode shared by the FSM and the datapath
   // --------------------------------------------------------------------------
   always_comb begin
      in_frame  = (state_q != IDLE);
      kill      = in_frame & i_abort;                      // abort wins over eof/sof
      take      = i_valid & ~kill & (in_frame | i_sof);
      restart   = take & i_sof;                            // byte 0 of a new frame
      close_old = in_frame & (i_abort | (i_valid & i_sof)); // open frame ends unfinished
      ending    = take & i_eof;
      push      = take & ~restart & (state_q == STREAM);
      crc_base  = restart ? CRC32_INIT : crc_q;
      len_base  = restart ? '0 : len_q;
      len_nx    = (&len_base) ? len_base : len_base + LEN_W'(1);
   end

   eth_crc32_d8 u_crc (
      .crc      (crc_base),
      .data     (i_byte),
      .crc_next (crc_nx)
   );

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge i_rx_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next state. fill counts held bytes while in FILL.
   // --------------------------------------------------------------------------
   // NOTE: every variable gets a default at the top of a combinational block
   // so that no path leaves it unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      if (kill) begin
         state_d = IDLE;
         fill_d  = '0;
      end else if (take) begin
         if (ending) begin
            state_d = IDLE;
            fill_d  = '0;
         end else if (restart) begin
            state_d = FILL;
            fill_d  = 2'd1;
         end else if (state_q == FILL) begin
            if (fill_q == 2'(FCS_BYTES - 1)) begin
               state_d = STREAM;
               fill_d  = '0;
            end else begin
               fill_d = fill_q + 2'd1;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // FSM: outputs (registered one cycle later). A mid-frame i_sof that also
   // carries i_eof reports only the aborted old frame; the 1-byte new frame
   // has no status slot left and is dropped.
   // --------------------------------------------------------------------------
   always_comb begin
      vld_d   = push;
      data_d  = push ? dl_q[FCS_BYTES-1] : 8'h00;
      sof_d   = push & ~fwd_q;
      eof_d   = push & i_eof;
      stat_d  = close_old | ending;
      abt_d   = close_old;
      ok_d    = 1'b0;
      slen_d  = '0;
      runt_d  = 1'b0;
      giant_d = 1'b0;
      if (close_old) begin
         slen_d = len_q;
      end else if (ending) begin
         slen_d = len_nx;
         ok_d   = (crc_nx == CRC32_RESIDUE);   // raw register, no final inversion
      end
      if (stat_d) begin
         runt_d  = (slen_d < LEN_W'(MIN_FRAME));
         giant_d = (slen_d > LEN_W'(MAX_FRAME)); // saturated count still exceeds MAX
      end
   end

   // --------------------------------------------------------------------------
   // Datapath registers: delay line, CRC, length, first-forward flag
   // --------------------------------------------------------------------------
   // NOTE: the delay line is small and must read as zero after reset, so it
   // is reset like any other register; on flush only fill/state are cleared
   // since stale bytes are never pushed out before being overwritten.
   always_ff @(posedge i_rx_clk) begin
      if (!i_rst_n) begin
         dl_q  <= '0;
         crc_q <= CRC32_INIT;
         len_q <= '0;
         fwd_q <= 1'b0;
      end else begin
         if (take) begin
            dl_q  <= {dl_q[FCS_BYTES-2:0], i_byte};
            crc_q <= crc_nx;
            len_q <= len_nx;
         end
         if (restart) begin
            fwd_q <= 1'b0;
         end else if (push) begin
            fwd_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_rx_clk) begin
      if (!i_rst_n) begin
         o_valid      <= 1'b0;
         o_data       <= '0;
         o_sof        <= 1'b0;
         o_eof        <= 1'b0;
         o_stat_valid <= 1'b0;
         o_crc_ok     <= 1'b0;
         o_runt       <= 1'b0;
         o_giant      <= 1'b0;
         o_aborted    <= 1'b0;
         o_len        <= '0;
      end else begin
         o_valid      <= vld_d;
         o_data       <= data_d;
         o_sof        <= sof_d;
         o_eof        <= eof_d;
         o_stat_valid <= stat_d;
         o_crc_ok     <= ok_d;
         o_runt       <= runt_d;
         o_giant      <= giant_d;
         o_aborted    <= abt_d;
         o_len        <= slen_d;
      end
   end

endmodule
